fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one sync data FIFO write port among NUM_REQ producers.
- Grants one requester at a time for a burst of up to MAX_BURST beats.
- Tags each beat with the source ID and drives the FIFO write port.
- Throttles new grants on FIFO almost_full; stalls beats on FIFO full.
- Sits directly in front of the shared FIFO in the compute datapath.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 32, payload width per requester
MAX_BURST, 4, maximum beats per grant (>=1)
ID_W (localparam), $clog2(NUM_REQ), source-ID width

Ports:
clock  input  1  clock
rstn  input  1  reset, asynchronous, active-low
req_valid  input  NUM_REQ  per-requester beat valid
req_last  input  NUM_REQ  per-requester last beat of packet
req_data  input  NUM_REQ*WIDTH  packed payloads; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  NUM_REQ  per-requester beat accept
fifo_wr_en  output  1  FIFO write strobe
fifo_wr_data  output  ID_W+WIDTH  {grant_id, payload}
fifo_full  input  1  FIFO full
fifo_almost_full  input  1  FIFO almost_full
busy  output  1  state==BURST
grant_id  output  ID_W  current or last granted requester (registered)
burst_count  output  16  number of completed bursts; wraps at 2^16

Behaviour:
Reset values (async, rstn low):
- state=IDLE, grant_id=0, beat_cnt=0, burst_count=0.
- last_grant=NUM_REQ-1, so requester 0 has first priority.
- All outputs 0; req_ready=0, fifo_wr_en=0.
- Reset mid-burst aborts the burst immediately. No beat is written in the reset cycle.

IDLE state:
- Grant condition: |req_valid && !fifo_almost_full.
- On grant, select the first set req_valid scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
- Register the winner into grant_id, clear beat_cnt, go to BURST.
- req_ready=0 in IDLE, so grant latency is 1 cycle.
- If almost_full is set, stay in IDLE with no grant.

BURST state:
- Ready: req_ready[grant_id] = !fifo_full. All other req_ready bits are 0.
- Beat: a beat transfers when req_valid[grant_id] && req_ready[grant_id].
- Same cycle as a beat: fifo_wr_en=1 and fifo_wr_data={grant_id, req_data[grant_id]}. The FIFO write path is combinational.
- fifo_wr_en is never 1 while fifo_full=1.
- fifo_almost_full does not stop an ongoing burst. Only fifo_full stalls it; a stalled beat waits without a timeout.
- Burst ends (next state IDLE, last_grant<=grant_id, burst_count++) on either:
  - a beat with req_last[grant_id]=1; or
  - a beat with beat_cnt==MAX_BURST-1.
- Otherwise, on a beat, beat_cnt++.
- Early release: if req_valid[grant_id]=0 while in BURST, go to IDLE next cycle.
  - last_grant<=grant_id and burst_count++ only if at least one beat was transferred (beat_cnt>0).
  - If no beat was transferred, last_grant is unchanged.
- At least one IDLE bubble cycle separates consecutive bursts.
- The round-robin pointer advances only on burst completion, never on a stall.

Other rules:
- beat_cnt width is $clog2(MAX_BURST+1). When MAX_BURST=1, every beat ends the burst.
- Inputs req_data, req_last and req_valid of non-granted requesters are ignored.

Test Plan:
1. Reset, req_valid=4'b0001, 3 beats data 0xA0..0xA2, last on 3rd -> grant in cycle 2; fifo_wr_data = 0x0_000000A0..A2 (ID 0); burst_count=1; back to IDLE.
2. All four requesting continuously with req_last=0, MAX_BURST=4 -> grants 0,1,2,3,0 in order; each burst exactly 4 beats; 1 idle cycle between bursts; burst_count=4 after 20 cycles of bursts.
3. fifo_full asserted for 3 cycles mid-burst of requester 2 -> req_ready[2]=0 and fifo_wr_en=0 for those 3 cycles; remaining beats resume in order with none lost or duplicated.
4. fifo_almost_full=1 in IDLE with req_valid=4'b1010 -> no grant and busy=0 until it deasserts; then grant_id=1 (pointer at 3 after reset scans 0,1).
5. Requester 1 granted and drops req_valid after 2 beats -> IDLE next cycle; burst_count+1; next grant goes to requester 2 if valid.
6. rstn pulsed low mid-burst (beat 2 of 4) -> all outputs 0 asynchronously; after release requester 0 wins first if valid.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants bursts of up to MAX_BURST beats and tags each beat with its source ID.
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 4,
   localparam int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                     clock,
   input  logic                     rstn,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_last,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     fifo_wr_en,
   output logic [ID_W+WIDTH-1:0]    fifo_wr_data,
   input  logic                     fifo_full,
   input  logic                     fifo_almost_full,
   output logic                     busy,
   output logic [ID_W-1:0]          grant_id,
   output logic [15:0]              burst_count
);
   localparam int BC_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state_reg, state_next;
   logic [ID_W-1:0]   grant_id_reg, grant_id_next;
   logic [ID_W-1:0]   last_grant_reg, last_grant_next;
   logic [BC_W-1:0]   beat_cnt_reg, beat_cnt_next;
   logic [15:0]       burst_count_reg, burst_count_next;

   logic [WIDTH-1:0]  payload [NUM_REQ];
   logic [2*NUM_REQ-1:0] rot_valid;
   logic [ID_W:0]     rot_amt;
   logic [ID_W-1:0]   rr_winner;
   logic              rr_found;
   int                rr_sum;
   logic              beat;
   logic              beat_ends_burst;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign payload[gi] = req_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Rotate the valid vector so bit j corresponds to requester last_grant+1+j.
   assign rot_amt   = {1'b0, last_grant_reg} + (ID_W+1)'(1);
   assign rot_valid = {req_valid, req_valid} >> rot_amt;

   always_comb begin
      rr_winner = last_grant_reg;
      rr_found  = 1'b0;
      rr_sum    = 0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (rot_valid[j]) begin
            rr_sum = int'(last_grant_reg) + 1 + j;
            if (rr_sum >= NUM_REQ) begin
               rr_sum = rr_sum - NUM_REQ;
            end
            rr_winner = ID_W'(rr_sum);
            rr_found  = 1'b1;
         end
      end
   end

   assign beat            = (state_reg == BURST) && req_valid[grant_id_reg] && !fifo_full;
   assign beat_ends_burst = req_last[grant_id_reg] || (beat_cnt_reg == BC_W'(MAX_BURST - 1));

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_reg       <= IDLE;
         grant_id_reg    <= '0;
         last_grant_reg  <= ID_W'(NUM_REQ - 1);
         beat_cnt_reg    <= '0;
         burst_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         grant_id_reg    <= grant_id_next;
         last_grant_reg  <= last_grant_next;
         beat_cnt_reg    <= beat_cnt_next;
         burst_count_reg <= burst_count_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      grant_id_next    = grant_id_reg;
      last_grant_next  = last_grant_reg;
      beat_cnt_next    = beat_cnt_reg;
      burst_count_next = burst_count_reg;
      case (state_reg)
         IDLE: begin
            if (rr_found && !fifo_almost_full) begin
               grant_id_next = rr_winner;
               beat_cnt_next = '0;
               state_next    = BURST;
            end
         end
         BURST: begin
            if (beat) begin
               if (beat_ends_burst) begin
                  state_next       = IDLE;
                  last_grant_next  = grant_id_reg;
                  burst_count_next = burst_count_reg + 16'd1;
               end else begin
                  beat_cnt_next = beat_cnt_reg + BC_W'(1);
               end
            end else if (!req_valid[grant_id_reg]) begin
               // Releasing before any beat leaves the pointer where it was.
               state_next = IDLE;
               if (beat_cnt_reg != '0) begin
                  last_grant_next  = grant_id_reg;
                  burst_count_next = burst_count_reg + 16'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      busy         = 1'b0;
      if (state_reg == BURST) begin
         busy                    = 1'b1;
         req_ready[grant_id_reg] = !fifo_full;
         fifo_wr_en              = beat;
         if (beat) begin
            fifo_wr_data = {grant_id_reg, payload[grant_id_reg]};
         end
      end
   end

   assign grant_id    = grant_id_reg;
   assign burst_count = burst_count_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized
// run checked against a round-robin reference model with per-requester queues.
module tb_fifo_wr_arbiter;
   localparam int N   = 4;
   localparam int W   = 32;
   localparam int MB  = 4;
   localparam int IDW = 2;

   logic            clock = 1'b0;
   logic            rstn;
   logic [N-1:0]    req_valid, req_last, req_ready;
   logic [N*W-1:0]  req_data;
   logic            fifo_wr_en, fifo_full, fifo_almost_full, busy;
   logic [IDW+W-1:0] fifo_wr_data;
   logic [IDW-1:0]  grant_id;
   logic [15:0]     burst_count;

   int tests = 0;
   int fails = 0;

   logic [W:0] q [N][$];

   fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
      .clock(clock), .rstn(rstn),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
      .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
      .busy(busy), .grant_id(grant_id), .burst_count(burst_count)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      req_valid = '0; req_last = '0; req_data = '0;
      fifo_full = 1'b0; fifo_almost_full = 1'b0;
      tick();
      rstn = 1'b1;
   endtask

   function automatic logic [IDW-1:0] rr_pick(input logic [IDW-1:0] last, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (int'(last) + k) % N;
         if (v[idx]) return IDW'(idx);
      end
      return last;
   endfunction

   task automatic test_reset();
      rstn = 1'b0;
      req_valid = '1; req_last = '0; req_data = {N{32'hDEADBEEF}};
      fifo_full = 1'b0; fifo_almost_full = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #3;
         tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
         tests++; if (grant_id !== '0) begin fails++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
         tests++; if (burst_count !== 16'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", burst_count); end
         tests++; if (req_ready !== '0 || fifo_wr_en !== 1'b0 || fifo_wr_data !== '0) begin
            fails++; $display("FAIL reset_outputs ready %b wr_en %b data %h exp all 0", req_ready, fifo_wr_en, fifo_wr_data);
         end
         tick();
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_single();
      apply_reset();
      req_valid = 4'b0001; req_data[W-1:0] = 32'hA0;
      #2;
      tests++; if (busy !== 1'b0 || req_ready !== '0) begin fails++; $display("FAIL single_idle busy %b ready %b exp 0", busy, req_ready); end
      tick();
      for (int b = 0; b < 3; b++) begin
         req_data[W-1:0] = W'(32'hA0 + b);
         req_last = (b == 2) ? 4'b0001 : 4'b0000;
         #2;
         tests++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== {2'd0, W'(32'hA0 + b)} || req_ready !== 4'b0001) begin
            fails++; $display("FAIL single_beat%0d wr_en %b data %h ready %b exp 1 %h 0001", b, fifo_wr_en, fifo_wr_data, req_ready, {2'd0, W'(32'hA0 + b)});
         end
         tick();
      end
      req_valid = '0; req_last = '0;
      #2;
      tests++; if (busy !== 1'b0 || burst_count !== 16'd1) begin fails++; $display("FAIL single_end busy %b count %0d exp 0 1", busy, burst_count); end
      $display("[TB] test_single done");
   endtask

   task automatic test_round_robin();
      apply_reset();
      req_valid = '1; req_last = '0;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(32'hB0 + i);
      for (int b = 0; b < 5; b++) begin
         int e;
         e = b % N;
         #2;
         tests++; if (busy !== 1'b0 || burst_count !== 16'(b)) begin
            fails++; $display("FAIL rr_gap%0d busy %b count %0d exp 0 %0d", b, busy, burst_count, b);
         end
         tick();
         for (int k = 0; k < MB; k++) begin
            #2;
            tests++; if (busy !== 1'b1 || grant_id !== IDW'(e) || fifo_wr_en !== 1'b1 || fifo_wr_data !== {IDW'(e), W'(32'hB0 + e)}) begin
               fails++; $display("FAIL rr_burst%0d_beat%0d busy %b gid %0d wr_en %b data %h exp gid %0d", b, k, busy, grant_id, fifo_wr_en, fifo_wr_data, e);
            end
            tick();
         end
      end
      $display("[TB] test_round_robin done");
   endtask

   task automatic test_full_stall();
      apply_reset();
      req_valid = 4'b0100; req_data[2*W +: W] = 32'hC0;
      #2;
      tick();
      req_data[2*W +: W] = 32'hC0;
      #2;
      tests++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== {2'd2, 32'hC0}) begin fails++; $display("FAIL stall_beat0 wr_en %b data %h", fifo_wr_en, fifo_wr_data); end
      tick();
      req_data[2*W +: W] = 32'hC1; fifo_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2;
         tests++; if (req_ready !== '0 || fifo_wr_en !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL stall_cycle%0d ready %b wr_en %b busy %b exp 0000 0 1", c, req_ready, fifo_wr_en, busy);
         end
         tick();
      end
      fifo_full = 1'b0;
      for (int k = 1; k < MB; k++) begin
         req_data[2*W +: W] = W'(32'hC0 + k);
         #2;
         tests++; if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0100 || fifo_wr_data !== {2'd2, W'(32'hC0 + k)}) begin
            fails++; $display("FAIL stall_resume%0d wr_en %b ready %b data %h", k, fifo_wr_en, req_ready, fifo_wr_data);
         end
         tick();
      end
      req_valid = '0;
      #2;
      tests++; if (busy !== 1'b0 || burst_count !== 16'd1) begin fails++; $display("FAIL stall_end busy %b count %0d exp 0 1", busy, burst_count); end
      $display("[TB] test_full_stall done");
   endtask

   task automatic test_almost_full();
      apply_reset();
      fifo_almost_full = 1'b1; req_valid = 4'b1010;
      for (int c = 0; c < 3; c++) begin
         #2;
         tests++; if (busy !== 1'b0 || req_ready !== '0) begin fails++; $display("FAIL af_hold%0d busy %b ready %b exp 0", c, busy, req_ready); end
         tick();
      end
      fifo_almost_full = 1'b0;
      tick();
      #2;
      tests++; if (busy !== 1'b1 || grant_id !== 2'd1) begin fails++; $display("FAIL af_grant busy %b gid %0d exp 1 1", busy, grant_id); end
      $display("[TB] test_almost_full done");
   endtask

   task automatic test_early_release();
      apply_reset();
      req_valid = 4'b0010; req_data[W +: W] = 32'hE0; req_data[2*W +: W] = 32'hF0;
      tick();
      for (int k = 0; k < 2; k++) begin
         req_data[W +: W] = W'(32'hE0 + k);
         #2;
         tests++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== {2'd1, W'(32'hE0 + k)}) begin
            fails++; $display("FAIL early_beat%0d wr_en %b data %h", k, fifo_wr_en, fifo_wr_data);
         end
         tick();
      end
      req_valid = 4'b0100;
      #2;
      tests++; if (fifo_wr_en !== 1'b0) begin fails++; $display("FAIL early_drop wr_en %b exp 0", fifo_wr_en); end
      tick();
      #2;
      tests++; if (busy !== 1'b0 || burst_count !== 16'd1) begin fails++; $display("FAIL early_idle busy %b count %0d exp 0 1", busy, burst_count); end
      tick();
      #2;
      tests++; if (busy !== 1'b1 || grant_id !== 2'd2 || fifo_wr_data !== {2'd2, 32'hF0}) begin
         fails++; $display("FAIL early_next busy %b gid %0d data %h exp 1 2", busy, grant_id, fifo_wr_data);
      end
      $display("[TB] test_early_release done");
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      req_valid = 4'b0011; req_data = {N{32'h55}};
      tick();
      tick();
      #2;
      tests++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'd0) begin fails++; $display("FAIL midrst_beat2 wr_en %b gid %0d exp 1 0", fifo_wr_en, grant_id); end
      rstn = 1'b0;
      #1;
      tests++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== '0 || fifo_wr_data !== '0 || burst_count !== 16'd0) begin
         fails++; $display("FAIL midrst_outputs busy %b wr_en %b ready %b data %h count %0d exp all 0", busy, fifo_wr_en, req_ready, fifo_wr_data, burst_count);
      end
      tick();
      rstn = 1'b1;
      #2;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_idle busy %b exp 0", busy); end
      tick();
      #2;
      tests++; if (busy !== 1'b1 || grant_id !== 2'd0) begin fails++; $display("FAIL midrst_regrant busy %b gid %0d exp 1 0", busy, grant_id); end
      $display("[TB] test_reset_mid_burst done");
   endtask

   task automatic test_random();
      logic            m_busy;
      logic [IDW-1:0]  m_gid, last_ptr;
      int              cur_len;
      logic [15:0]     exp_bursts;
      logic            exp_beat, is_last;
      logic [N-1:0]    exp_ready;
      apply_reset();
      m_busy = 1'b0; m_gid = '0; last_ptr = IDW'(N - 1); cur_len = 0; exp_bursts = '0;
      for (int i = 0; i < N; i++) q[i].delete();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int i = 0; i < N; i++) begin
            while (q[i].size() < 3) q[i].push_back({($urandom_range(0, 3) == 0), W'($urandom)});
            req_valid[i] = ($urandom_range(0, 9) < 8);
            req_last[i]  = q[i][0][W];
            req_data[i*W +: W] = q[i][0][W-1:0];
         end
         fifo_full        = ($urandom_range(0, 4) == 0);
         fifo_almost_full = ($urandom_range(0, 3) == 0);
         #2;
         tests++; if (busy !== m_busy) begin fails++; $display("FAIL rnd_busy cyc %0d got %b exp %b", cyc, busy, m_busy); end
         tests++; if (burst_count !== exp_bursts) begin fails++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, burst_count, exp_bursts); end
         if (m_busy) begin
            exp_ready = fifo_full ? '0 : (N'(1) << m_gid);
            exp_beat  = req_valid[m_gid] && !fifo_full;
            tests++; if (grant_id !== m_gid) begin fails++; $display("FAIL rnd_gid cyc %0d got %0d exp %0d", cyc, grant_id, m_gid); end
            tests++; if (req_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, req_ready, exp_ready); end
            tests++; if (fifo_wr_en !== exp_beat) begin fails++; $display("FAIL rnd_wr_en cyc %0d got %b exp %b", cyc, fifo_wr_en, exp_beat); end
            if (exp_beat) begin
               tests++; if (fifo_wr_data !== {m_gid, q[m_gid][0][W-1:0]}) begin
                  fails++; $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, fifo_wr_data, {m_gid, q[m_gid][0][W-1:0]});
               end
               is_last = q[m_gid][0][W];
               void'(q[m_gid].pop_front());
               cur_len++;
               if (is_last || cur_len == MB) begin
                  exp_bursts++; last_ptr = m_gid; m_busy = 1'b0;
               end
            end else if (!req_valid[m_gid]) begin
               if (cur_len > 0) begin
                  exp_bursts++; last_ptr = m_gid;
               end
               m_busy = 1'b0;
            end
         end else begin
            tests++; if (req_ready !== '0 || fifo_wr_en !== 1'b0) begin
               fails++; $display("FAIL rnd_idle cyc %0d ready %b wr_en %b exp 0", cyc, req_ready, fifo_wr_en);
            end
            if (|req_valid && !fifo_almost_full) begin
               m_gid = rr_pick(last_ptr, req_valid); m_busy = 1'b1; cur_len = 0;
            end
         end
         tick();
      end
      $display("[TB] test_random done, %0d bursts", exp_bursts);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full_stall();
      test_almost_full();
      test_early_release();
      test_reset_mid_burst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
